clos_port_arbiter: RTL and testbench



---
 rtl/clos_pkg.sv | 26 ++
 rtl/clos_port_arbiter_chk.sv | 14 +
 rtl/clos_rr_select.sv | 51 +++++
 rtl/clos_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_clos_port_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clos_pkg.sv
// Shared types, helpers and one-hot assertion macros for the Clos node port arbiter.
`ifndef CLOS_PKG_SV
`define CLOS_PKG_SV

`define CLOS_ASSERT_ONEHOT0(lbl, clk, rst, sig) \
    lbl: assert property (@(posedge clk) disable iff (rst) $onehot0(sig));

package clos_pkg;

    localparam int unsigned ClosNumIn = 4;
    localparam int unsigned ClosIdxW  = $clog2(ClosNumIn);

    typedef logic [ClosIdxW-1:0] clos_idx_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        if (ptr + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

`endif

// File: rtl/clos_port_arbiter_chk.sv
// One-hot properties on the grant and response-valid vectors of the port arbiter.
module clos_port_arbiter_chk #(
    parameter int unsigned NumIn = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic [NumIn-1:0] gnt_o,
    input logic [NumIn-1:0] vld_o
);

    `CLOS_ASSERT_ONEHOT0(a_gnt_onehot0, clk_i, rst_i, gnt_o)
    `CLOS_ASSERT_ONEHOT0(a_vld_onehot0, clk_i, rst_i, vld_o)

endmodule

// File: rtl/clos_rr_select.sv
// Combinational winner picker: rotated lowest-set-bit search from ptr, overridden
// by the lowest starved requester when any requester has waited too long.
module clos_rr_select
    import clos_pkg::*;
#(
    parameter int unsigned NumIn = 4
) (
    input  logic [NumIn-1:0]         req_i,
    input  logic [$clog2(NumIn)-1:0] ptr_i,
    input  logic [NumIn-1:0]         starved_i,
    output logic [$clog2(NumIn)-1:0] winner_o,
    output logic                     any_o
);

    localparam int unsigned IdxW = $clog2(NumIn);

    logic [2*NumIn-1:0] rot_full_s;
    logic [NumIn-1:0]   rot_s;
    logic [IdxW-1:0]    rr_off_s;
    logic [IdxW-1:0]    rr_win_s;
    logic [IdxW-1:0]    st_idx_s;
    logic               st_any_s;

    // Rotate so bit 0 is the pointer position, then find the first set bit.
    always_comb begin
        rot_full_s = {req_i, req_i} >> ptr_i;
        rot_s      = rot_full_s[NumIn-1:0];
        rr_off_s   = '0;
        st_idx_s   = '0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            rr_off_s = rot_s[i]     ? IdxW'(i) : rr_off_s;
            st_idx_s = starved_i[i] ? IdxW'(i) : st_idx_s;
        end
        rr_win_s = ptr_i + rr_off_s;
        st_any_s = |starved_i;
        any_o    = |req_i;
    end

    // Starvation override has priority over round-robin; idle keeps the pointer.
    always_comb begin
        winner_o = ptr_i;
        if (st_any_s) begin
            winner_o = st_idx_s;
        end else if (any_o) begin
            winner_o = rr_win_s;
        end else begin
            winner_o = ptr_i;
        end
    end

endmodule

// File: rtl/clos_port_arbiter.sv
// Starvation-safe round-robin arbiter for one Clos output port, with a fixed-latency
// response pipeline routing rdata back to the requester that won the handshake.
module clos_port_arbiter
    import clos_pkg::*;
#(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned MemLatency    = 1,
    parameter int unsigned MaxWait       = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumIn-1:0]                    req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]  data_i,
    output logic [NumIn-1:0]                    gnt_o,
    output logic                                req_o,
    output logic [ReqDataWidth-1:0]             data_o,
    input  logic                                gnt_i,
    output logic [$clog2(NumIn)-1:0]            idx_o,
    input  logic [RespDataWidth-1:0]            rdata_i,
    output logic [NumIn-1:0]                    vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0] rdata_o
);

    localparam int unsigned IdxW  = $clog2(NumIn);
    localparam int unsigned WaitW = $clog2(MaxWait + 1);

    logic [IdxW-1:0]  ptr_q;
    logic [IdxW-1:0]  ptr_d;
    logic [IdxW-1:0]  winner_s;
    logic             any_s;
    logic             hs_s;
    logic [NumIn-1:0] starved_s;

    logic [WaitW-1:0] wait_q [NumIn];
    logic [WaitW-1:0] wait_d [NumIn];

    logic [MemLatency-1:0] pv_q;
    logic [MemLatency-1:0] pv_d;
    logic [IdxW-1:0]       pidx_q [MemLatency];
    logic [IdxW-1:0]       pidx_d [MemLatency];

    // A requester is starved once it has lost MaxWait cycles in a row.
    always_comb begin
        for (int i = 0; i < NumIn; i++) begin
            starved_s[i] = req_i[i] & (wait_q[i] >= WaitW'(MaxWait));
        end
    end

    clos_rr_select #(
        .NumIn (NumIn)
    ) u_select (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .starved_i (starved_s),
        .winner_o  (winner_s),
        .any_o     (any_s)
    );

    // Zero-latency request path towards the slave.
    always_comb begin
        req_o  = any_s;
        hs_s   = any_s & gnt_i;
        idx_o  = winner_s;
        data_o = data_i[winner_s];
        gnt_o  = '0;
        if (hs_s) begin
            gnt_o[winner_s] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

    // Pointer rotates only on an accepted handshake; wait counters saturate.
    always_comb begin
        if (hs_s) begin
            ptr_d = IdxW'(rr_next(32'(winner_s), NumIn));
        end else begin
            ptr_d = ptr_q;
        end
        for (int i = 0; i < NumIn; i++) begin
            if (!req_i[i]) begin
                wait_d[i] = '0;
            end else if (hs_s && (winner_s == IdxW'(i))) begin
                wait_d[i] = '0;
            end else if (wait_q[i] < WaitW'(MaxWait)) begin
                wait_d[i] = wait_q[i] + WaitW'(1);
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
    end

    // Response tracking shift register, advancing every cycle without stall.
    always_comb begin
        pv_d[0]   = hs_s;
        pidx_d[0] = winner_s;
        for (int s = 1; s < MemLatency; s++) begin
            pv_d[s]   = pv_q[s-1];
            pidx_d[s] = pidx_q[s-1];
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            pv_q  <= '0;
            for (int i = 0; i < NumIn; i++) begin
                wait_q[i] <= '0;
            end
            for (int s = 0; s < MemLatency; s++) begin
                pidx_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            pv_q  <= pv_d;
            for (int i = 0; i < NumIn; i++) begin
                wait_q[i] <= wait_d[i];
            end
            for (int s = 0; s < MemLatency; s++) begin
                pidx_q[s] <= pidx_d[s];
            end
        end
    end

    // Final pipeline stage steers the response valid; data is broadcast.
    always_comb begin
        vld_o = '0;
        if (pv_q[MemLatency-1]) begin
            vld_o[pidx_q[MemLatency-1]] = 1'b1;
        end else begin
            vld_o = '0;
        end
        for (int i = 0; i < NumIn; i++) begin
            rdata_o[i] = rdata_i;
        end
    end

    clos_port_arbiter_chk #(
        .NumIn (NumIn)
    ) u_chk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .gnt_o (gnt_o),
        .vld_o (vld_o)
    );

endmodule

// File: tb/tb_clos_port_arbiter.sv
// Scoreboard bench for clos_port_arbiter: a reference model predicts winners and
// queues expected responses, which are popped when vld_o is due.
module tb_clos_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int ML = 3;
    localparam int MW = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N-1:0]           req_i;
    logic [N-1:0][DW-1:0]   data_i;
    logic [N-1:0]           gnt_o;
    logic                   req_o;
    logic [DW-1:0]          data_o;
    logic                   gnt_i;
    logic [1:0]             idx_o;
    logic [RW-1:0]          rdata_i;
    logic [N-1:0]           vld_o;
    logic [N-1:0][RW-1:0]   rdata_o;

    always #5 clk_i = ~clk_i;

    clos_port_arbiter #(
        .NumIn         (N),
        .ReqDataWidth  (DW),
        .RespDataWidth (RW),
        .MemLatency    (ML),
        .MaxWait       (MW)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .gnt_o   (gnt_o),
        .req_o   (req_o),
        .data_o  (data_o),
        .gnt_i   (gnt_i),
        .idx_o   (idx_o),
        .rdata_i (rdata_i),
        .vld_o   (vld_o),
        .rdata_o (rdata_o)
    );

    typedef struct {
        int due;
        int idx;
    } resp_t;

    int    checks_cnt = 0;
    int    errors_cnt = 0;
    int    m_ptr;
    int    m_wait [N];
    int    m_win;
    int    cyc;
    resp_t sb_q [$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_winner();
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && m_wait[i] >= MW) return i;
        end
        for (int k = 0; k < N; k++) begin
            if (req_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return m_ptr;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        sb_q.delete();
    endtask

    // Apply inputs, then check the combinational outputs and the due response.
    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rst);
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_vld;
        resp_t        r;
        req_i   = req;
        gnt_i   = gnt;
        rst_i   = rst;
        rdata_i = $urandom;
        if (rst) model_reset();
        #1;
        m_win = model_winner();
        exp_gnt = (|req && gnt) ? (4'b0001 << m_win) : 4'b0000;
        check_val("idx_o", idx_o, m_win);
        check_val("req_o", req_o, |req);
        check_val("gnt_o", gnt_o, exp_gnt);
        check_val("data_o", data_o, data_i[m_win]);
        exp_vld = 4'b0000;
        if (!rst && sb_q.size() > 0 && sb_q[0].due == cyc) begin
            r = sb_q.pop_front();
            exp_vld = 4'b0001 << r.idx;
            check_val("rdata_o", rdata_o[r.idx], rdata_i);
        end
        check_val("vld_o", vld_o, exp_vld);
    endtask

    // Clock edge: advance the reference model with the inputs just applied.
    task automatic tick();
        logic hs;
        @(posedge clk_i);
        if (!rst_i) begin
            hs = (|req_i) && gnt_i;
            for (int i = 0; i < N; i++) begin
                if (!req_i[i]) m_wait[i] = 0;
                else if (hs && i == m_win) m_wait[i] = 0;
                else if (m_wait[i] < MW) m_wait[i] = m_wait[i] + 1;
            end
            if (hs) begin
                sb_q.push_back('{due: cyc + ML, idx: m_win});
                m_ptr = (m_win + 1) % N;
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b1);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(4'b0000, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [N-1:0] rq;
        logic         g;
        int           w;
        cyc = 0;
        req_i = '0;
        gnt_i = 1'b0;
        rst_i = 1'b1;
        rdata_i = '0;
        model_reset();
        for (int i = 0; i < N; i++) data_i[i] = $urandom;

        // Reset held with full request and grant
        repeat (3) begin
            drive(4'b1111, 1'b1, 1'b1);
            check_val("rst_vld", vld_o, 4'b0000);
            tick();
        end
        drive(4'b1111, 1'b1, 1'b0);
        check_val("first_idx", idx_o, 0);
        tick();
        drive(4'b1111, 1'b1, 1'b0);
        check_val("second_idx", idx_o, 1);
        tick();

        // Fairness
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 1'b1, 1'b0);
            check_val("fair_idx", idx_o, k % 4);
            tick();
        end
        idle(ML + 1);

        // Stalled slave
        do_reset();
        repeat (5) begin
            drive(4'b0110, 1'b0, 1'b0);
            check_val("stall_gnt", gnt_o, 4'b0000);
            check_val("stall_idx", idx_o, 1);
            tick();
        end
        drive(4'b0110, 1'b1, 1'b0);
        check_val("stall_win", idx_o, 1);
        tick();
        drive(4'b0100, 1'b1, 1'b0);
        check_val("stall_next", idx_o, 2);
        tick();
        idle(ML + 1);

        // Starvation override
        do_reset();
        repeat (MW) begin
            drive(4'b1000, 1'b0, 1'b0);
            tick();
        end
        drive(4'b1011, 1'b1, 1'b0);
        check_val("starve_win", idx_o, 3);
        check_val("starve_gnt", gnt_o, 4'b1000);
        tick();
        drive(4'b0011, 1'b1, 1'b0);
        check_val("starve_after", idx_o, 0);
        tick();
        idle(ML + 1);

        // Latency of a single handshake
        do_reset();
        data_i[2] = 32'hCAFE_0002;
        drive(4'b0100, 1'b1, 1'b0);
        check_val("lat_data", data_o, 32'hCAFE_0002);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(4'b0000, 1'b0, 1'b0);
            check_val("lat_vld", vld_o, (k == ML) ? 4'b0100 : 4'b0000);
            tick();
        end

        // Reset with responses in flight
        do_reset();
        drive(4'b1111, 1'b1, 1'b0);
        tick();
        drive(4'b1111, 1'b1, 1'b0);
        tick();
        drive(4'b1111, 1'b1, 1'b1);
        tick();
        drive(4'b1111, 1'b0, 1'b0);
        check_val("flush_ptr", idx_o, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0000, 1'b0, 1'b0);
            check_val("flush_vld", vld_o, 4'b0000);
            tick();
        end

        // Random traffic; requests and payloads held until granted
        do_reset();
        rq = '0;
        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(0, 2) == 0) begin
                    rq[i] = 1'b1;
                    data_i[i] = $urandom;
                end
            end
            g = ($urandom_range(0, 3) != 0);
            drive(rq, g, 1'b0);
            w = m_win;
            tick();
            if (|rq && g) rq[w] = 1'b0;
        end
        idle(ML + 1);
        check_val("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
